h8_mem: RTL and testbench

Memory and I/O responder for the hex8 core: the target end of the core's instruction- and data-memory request interfaces. It holds a 256×8 unified store serving a read-only instruction port and a read/write data port, each with fixed one-cycle latency and no backpressure. A host byte-stream loader programs the store while the core is held in reset. A memory-mapped output FIFO at the top of the data address space gives programs a byte output channel.

---
 rtl/h8_mem.sv | 162 ++++++++++++++++
 tb/tb_h8_mem.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/h8_mem.sv
// Unified 256x8 store for the hex8 core: instruction port, data port with MMIO
// output FIFO at 0xFE/0xFF, and a host byte loader that programs RAM while the core is held in reset.
module h8_mem (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_imem_req_addr,
    input  logic       i_imem_req_valid,
    output logic [7:0] o_imem_rsp_data,
    input  logic [7:0] i_dmem_req_addr,
    input  logic [7:0] i_dmem_req_data,
    input  logic       i_dmem_req_write,
    input  logic       i_dmem_req_valid,
    output logic [7:0] o_dmem_rsp_data,
    output logic       o_core_rst,
    input  logic       i_load_start,
    input  logic       i_load_valid,
    input  logic [7:0] i_load_data,
    output logic       o_load_ready,
    input  logic       i_load_done,
    output logic       o_out_valid,
    output logic [7:0] o_out_data,
    input  logic       i_out_ready
);

    // state | meaning
    // LOAD  | core held in reset, loader bytes written to mem[ptr]
    // RUN   | core running, imem/dmem requests served
    typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;

    state_t     state;
    logic [7:0] ptr;
    logic [7:0] mem [0:255];

    logic [7:0] fifo_q [0:3];
    logic [1:0] rd_idx;
    logic [1:0] wr_idx;
    logic [2:0] level;
    logic       overflow;

    logic       run_req;
    logic       d_wr;
    logic       d_rd;
    logic       ram_wr;
    logic       push;
    logic       clr_ovf;
    logic       pop;
    logic       full;
    logic       push_ok;
    logic       load_acc;
    logic       mem_we;
    logic [7:0] mem_waddr;
    logic [7:0] mem_wdata;
    logic [7:0] status;

    // A load_start in RUN drops that cycle's core request: the next cycle is LOAD.
    assign run_req  = (state == RUN) && !i_load_start;
    assign d_wr     = run_req && i_dmem_req_valid && i_dmem_req_write;
    assign d_rd     = run_req && i_dmem_req_valid && !i_dmem_req_write;
    assign ram_wr   = d_wr && (i_dmem_req_addr < 8'hFE);
    assign push     = d_wr && (i_dmem_req_addr == 8'hFF);
    assign clr_ovf  = d_wr && (i_dmem_req_addr == 8'hFE);
    assign load_acc = (state == LOAD) && i_load_valid;

    assign o_out_valid = (level != 3'd0);
    assign o_out_data  = fifo_q[rd_idx];
    assign pop         = o_out_valid && i_out_ready;
    assign full        = (level == 3'd4);
    assign push_ok     = push && (!full || pop);
    assign status      = {overflow, 4'b0000, level};

    assign mem_we    = load_acc || ram_wr;
    assign mem_waddr = (state == LOAD) ? ptr : i_dmem_req_addr;
    assign mem_wdata = (state == LOAD) ? i_load_data : i_dmem_req_data;

    always_ff @(posedge i_clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= LOAD;
            ptr          <= 8'h00;
            o_core_rst   <= 1'b1;
            o_load_ready <= 1'b1;
        end else begin
            case (state)
                LOAD: begin
                    if (i_load_start)
                        ptr <= 8'h00;
                    else if (i_load_valid)
                        ptr <= ptr + 8'd1;
                    if (i_load_done || (i_load_valid && !i_load_start && ptr == 8'hFF)) begin
                        state        <= RUN;
                        o_core_rst   <= 1'b0;
                        o_load_ready <= 1'b0;
                    end
                end
                RUN: begin
                    if (i_load_start) begin
                        state        <= LOAD;
                        ptr          <= 8'h00;
                        o_core_rst   <= 1'b1;
                        o_load_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_imem_rsp_data <= 8'h00;
            o_dmem_rsp_data <= 8'h00;
        end else if (!run_req) begin
            o_imem_rsp_data <= 8'h00;
            o_dmem_rsp_data <= 8'h00;
        end else begin
            // Same-cycle RAM write forwards to the instruction read.
            if (i_imem_req_valid) begin
                if (ram_wr && (i_dmem_req_addr == i_imem_req_addr))
                    o_imem_rsp_data <= i_dmem_req_data;
                else
                    o_imem_rsp_data <= mem[i_imem_req_addr];
            end
            if (d_rd) begin
                case (i_dmem_req_addr)
                    8'hFE:   o_dmem_rsp_data <= status;
                    8'hFF:   o_dmem_rsp_data <= 8'h00;
                    default: o_dmem_rsp_data <= mem[i_dmem_req_addr];
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 4; i++)
                fifo_q[i] <= 8'h00;
            rd_idx   <= 2'd0;
            wr_idx   <= 2'd0;
            level    <= 3'd0;
            overflow <= 1'b0;
        end else begin
            if (pop)
                rd_idx <= rd_idx + 2'd1;
            if (push_ok) begin
                fifo_q[wr_idx] <= i_dmem_req_data;
                wr_idx         <= wr_idx + 2'd1;
            end
            level <= level + {2'b00, push_ok} - {2'b00, pop};
            if (push && full && !pop)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_h8_mem.sv
// Randomized self-checking bench for h8_mem against a queue/array reference model.
module tb_h8_mem;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] imem_addr = 8'h00;
    logic       imem_valid = 1'b0;
    logic [7:0] imem_rsp;
    logic [7:0] dmem_addr = 8'h00;
    logic [7:0] dmem_data = 8'h00;
    logic       dmem_write = 1'b0;
    logic       dmem_valid = 1'b0;
    logic [7:0] dmem_rsp;
    logic       core_rst;
    logic       load_start = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic       load_ready;
    logic       load_done = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    h8_mem dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_imem_req_addr  (imem_addr),
        .i_imem_req_valid (imem_valid),
        .o_imem_rsp_data  (imem_rsp),
        .i_dmem_req_addr  (dmem_addr),
        .i_dmem_req_data  (dmem_data),
        .i_dmem_req_write (dmem_write),
        .i_dmem_req_valid (dmem_valid),
        .o_dmem_rsp_data  (dmem_rsp),
        .o_core_rst       (core_rst),
        .i_load_start     (load_start),
        .i_load_valid     (load_valid),
        .i_load_data      (load_data),
        .o_load_ready     (load_ready),
        .i_load_done      (load_done),
        .o_out_valid      (out_valid),
        .o_out_data       (out_data),
        .i_out_ready      (out_ready)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: RAM as an array, FIFO as a queue, mode as a bit.
    bit         m_run = 1'b0;
    int         m_ptr = 0;
    logic [7:0] m_mem [256];
    bit         m_def [256];
    logic [7:0] m_q [$];
    bit         m_ovf = 1'b0;
    logic [7:0] m_irsp = 8'h00;
    logic [7:0] m_drsp = 8'h00;
    bit         m_ik = 1'b0;
    bit         m_dk = 1'b0;
    bit         m_pop, m_push, m_clr, m_wr_ram;
    logic [7:0] m_status;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run  = 1'b0;
            m_ptr  = 0;
            m_q.delete();
            m_ovf  = 1'b0;
            m_irsp = 8'h00;
            m_drsp = 8'h00;
            m_ik   = 1'b1;
            m_dk   = 1'b1;
        end else begin
            m_pop    = (m_q.size() > 0) && out_ready;
            m_status = {m_ovf, 4'b0000, 3'(m_q.size())};
            m_push   = 1'b0;
            m_clr    = 1'b0;
            m_wr_ram = 1'b0;
            if (m_run && !load_start) begin
                if (dmem_valid && dmem_write) begin
                    if (dmem_addr == 8'hFF)      m_push = 1'b1;
                    else if (dmem_addr == 8'hFE) m_clr = 1'b1;
                    else                         m_wr_ram = 1'b1;
                end
                if (imem_valid) begin
                    if (m_wr_ram && dmem_addr == imem_addr) begin
                        m_irsp = dmem_data;
                        m_ik   = 1'b1;
                    end else begin
                        m_irsp = m_mem[imem_addr];
                        m_ik   = m_def[imem_addr];
                    end
                end
                if (dmem_valid && !dmem_write) begin
                    m_dk = 1'b1;
                    if (dmem_addr == 8'hFF)      m_drsp = 8'h00;
                    else if (dmem_addr == 8'hFE) m_drsp = m_status;
                    else begin
                        m_drsp = m_mem[dmem_addr];
                        m_dk   = m_def[dmem_addr];
                    end
                end
                if (m_wr_ram) begin
                    m_mem[dmem_addr] = dmem_data;
                    m_def[dmem_addr] = 1'b1;
                end
            end else begin
                m_irsp = 8'h00;
                m_drsp = 8'h00;
                m_ik   = 1'b1;
                m_dk   = 1'b1;
                if (m_run) begin
                    m_run = 1'b0;
                    m_ptr = 0;
                end else begin
                    if (load_valid) begin
                        m_mem[m_ptr] = load_data;
                        m_def[m_ptr] = 1'b1;
                    end
                    if (load_done || (load_valid && !load_start && m_ptr == 255))
                        m_run = 1'b1;
                    if (load_start)      m_ptr = 0;
                    else if (load_valid) m_ptr = (m_ptr + 1) % 256;
                end
            end
            if (m_pop)
                void'(m_q.pop_front());
            if (m_push) begin
                if (m_q.size() < 4) m_q.push_back(dmem_data);
                else                m_ovf = 1'b1;
            end else if (m_clr) begin
                m_ovf = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("core_rst", {7'b0, core_rst}, {7'b0, !m_run});
        chk("load_ready", {7'b0, load_ready}, {7'b0, !m_run});
        chk("out_valid", {7'b0, out_valid}, {7'b0, m_q.size() > 0});
        if (m_q.size() > 0) chk("out_data", out_data, m_q[0]);
        if (m_ik) chk("imem_rsp", imem_rsp, m_irsp);
        if (m_dk) chk("dmem_rsp", dmem_rsp, m_drsp);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        imem_valid = 1'b0;
        dmem_valid = 1'b0;
        dmem_write = 1'b0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_done  = 1'b0;
    endtask

    task automatic dwrite(input logic [7:0] a, input logic [7:0] d);
        dmem_valid = 1'b1;
        dmem_write = 1'b1;
        dmem_addr  = a;
        dmem_data  = d;
    endtask

    task automatic dread(input logic [7:0] a);
        dmem_valid = 1'b1;
        dmem_write = 1'b0;
        dmem_addr  = a;
    endtask

    task automatic rand_core();
        imem_valid = 1'($urandom);
        imem_addr  = 8'($urandom);
        dmem_valid = 1'($urandom);
        dmem_write = 1'($urandom);
        dmem_addr  = ($urandom_range(0, 9) < 3) ? (8'hFE | 8'($urandom_range(0, 1))) : 8'($urandom);
        dmem_data  = 8'($urandom);
    endtask

    task automatic reload();
        int n;
        idle();
        load_start = 1'b1;
        tick();
        idle();
        n = $urandom_range(0, 12);
        for (int i = 0; i < n; i++) begin
            rand_core();
            load_valid = 1'($urandom);
            load_data  = 8'($urandom);
            tick();
        end
        idle();
        load_done = 1'b1;
        tick();
        idle();
    endtask

    logic [7:0] seq5 [4];

    initial begin
        idle();
        #1 rst_n = 1'b0;
        #1;
        chk("rst core_rst", {7'b0, core_rst}, 8'h01);
        chk("rst load_ready", {7'b0, load_ready}, 8'h01);
        chk("rst imem_rsp", imem_rsp, 8'h00);
        chk("rst dmem_rsp", dmem_rsp, 8'h00);
        chk("rst out_valid", {7'b0, out_valid}, 8'h00);
        chk("rst out_data", out_data, 8'h00);
        #20 rst_n = 1'b1;
        tick();

        // Short load then explicit done.
        load_valid = 1'b1; load_data = 8'h11; tick();
        load_data = 8'h22; tick();
        load_data = 8'h33; tick();
        idle(); load_done = 1'b1; tick();
        idle();
        chk("done core_rst", {7'b0, core_rst}, 8'h00);
        imem_valid = 1'b1; imem_addr = 8'h00; tick(); chk("imem 00", imem_rsp, 8'h11);
        imem_addr = 8'h01; tick(); chk("imem 01", imem_rsp, 8'h22);
        imem_addr = 8'h02; tick(); chk("imem 02", imem_rsp, 8'h33);
        idle();

        // Full 256-byte load with auto-exit on wrap.
        load_start = 1'b1; tick(); idle();
        chk("reload core_rst", {7'b0, core_rst}, 8'h01);
        for (int i = 0; i < 256; i++) begin
            load_valid = 1'b1;
            load_data  = 8'(i);
            if (i == 255) chk("pre-wrap core_rst", {7'b0, core_rst}, 8'h01);
            tick();
        end
        idle();
        chk("wrap core_rst", {7'b0, core_rst}, 8'h00);
        chk("wrap load_ready", {7'b0, load_ready}, 8'h00);
        for (int i = 0; i < 256; i++) begin
            imem_valid = 1'b1;
            imem_addr  = 8'(i);
            tick();
            chk("wrap imem", imem_rsp, 8'(i));
        end
        idle();

        // Write forwarding to the instruction port.
        dwrite(8'h40, 8'h5A); imem_valid = 1'b1; imem_addr = 8'h40; tick();
        chk("fwd imem", imem_rsp, 8'h5A);
        idle(); dread(8'h40); tick();
        chk("fwd dmem", dmem_rsp, 8'h5A);
        idle();

        // FIFO overflow.
        out_ready = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            dwrite(8'hFF, 8'(v));
            tick();
        end
        idle(); dread(8'hFE); tick();
        chk("ovf status", dmem_rsp, 8'h84);
        idle(); out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain valid", {7'b0, out_valid}, 8'h01);
            chk("drain data", out_data, 8'(i));
            tick();
        end
        chk("drained", {7'b0, out_valid}, 8'h00);
        out_ready = 1'b0;
        dwrite(8'hFE, 8'hA5); tick();
        idle(); dread(8'hFE); tick();
        chk("ovf cleared", dmem_rsp, 8'h00);
        idle();

        // Full FIFO with simultaneous push and pop.
        for (int v = 0; v < 4; v++) begin
            dwrite(8'hFF, 8'h91 + 8'(v));
            tick();
        end
        out_ready = 1'b1; dwrite(8'hFF, 8'h99); tick();
        out_ready = 1'b0; idle(); dread(8'hFE); tick();
        chk("pushpop status", dmem_rsp, 8'h04);
        idle(); out_ready = 1'b1;
        seq5[0] = 8'h92; seq5[1] = 8'h93; seq5[2] = 8'h94; seq5[3] = 8'h99;
        for (int i = 0; i < 4; i++) begin
            chk("pushpop data", out_data, seq5[i]);
            tick();
        end
        chk("pushpop empty", {7'b0, out_valid}, 8'h00);
        out_ready = 1'b0;

        // Randomized traffic with occasional reloads.
        for (int c = 0; c < 3000; c++) begin
            idle();
            if ($urandom_range(0, 99) < 2) begin
                reload();
            end else begin
                rand_core();
                out_ready = ($urandom_range(0, 9) < 7);
                tick();
            end
        end
        idle();

        // Asynchronous reset mid-run with two FIFO entries.
        out_ready = 1'b1;
        repeat (6) tick();
        out_ready = 1'b0;
        dwrite(8'hFF, 8'hE1); tick();
        dwrite(8'hFF, 8'hE2); tick();
        dwrite(8'h10, 8'h77); tick();
        idle(); dread(8'h10); imem_valid = 1'b1; imem_addr = 8'h10; tick();
        idle();
        chk("pre-rst imem", imem_rsp, 8'h77);
        chk("pre-rst out_valid", {7'b0, out_valid}, 8'h01);
        #1 rst_n = 1'b0;
        #1;
        chk("arst core_rst", {7'b0, core_rst}, 8'h01);
        chk("arst load_ready", {7'b0, load_ready}, 8'h01);
        chk("arst out_valid", {7'b0, out_valid}, 8'h00);
        chk("arst imem_rsp", imem_rsp, 8'h00);
        chk("arst dmem_rsp", dmem_rsp, 8'h00);
        #10 rst_n = 1'b1;
        tick();
        load_valid = 1'b1; load_data = 8'hC3; tick();
        idle(); load_done = 1'b1; tick();
        idle(); imem_valid = 1'b1; imem_addr = 8'h00; tick();
        chk("post-rst ptr0", imem_rsp, 8'hC3);
        imem_addr = 8'h10; tick();
        chk("post-rst kept", imem_rsp, 8'h77);
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
